// File: rtl/kyber_reduce_sequencer.sv
// kyber_reduce_sequencer
// Initiator-side controller for the Kyber reduction core (x mod MODULUS).
// Takes coefficients from an upstream valid/ready stream and issues one
// start-pulse transaction per coefficient to the core. It then returns each
// reduced result downstream, in input order, on a valid/ready stream.
// Zero coefficients bypass the core. It counts polynomial batches and raises
// a sticky flag when the core does not respond.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i     upstream coefficient stream
//   core_start_o/core_x_o/core_m_o      request to the reduction core
//   core_valid_i/core_result_i          response from the reduction core
//   out_valid_o/out_ready_i/out_data_o  downstream result stream
//   batch_done_o         one-cycle pulse after every BATCH_LEN-th output
//   error_o              sticky core-timeout flag
module kyber_reduce_sequencer #(
    parameter int unsigned DATA_LENGTH  = 32,
    parameter int unsigned MODULUS      = 3329,
    parameter int unsigned BATCH_LEN    = 256,
    parameter int unsigned CORE_TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_LENGTH-1:0] in_data_i,
    output logic                   core_start_o,
    output logic [DATA_LENGTH-1:0] core_x_o,
    output logic [DATA_LENGTH-1:0] core_m_o,
    input  logic                   core_valid_i,
    input  logic [DATA_LENGTH-1:0] core_result_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_LENGTH-1:0] out_data_o,
    output logic                   batch_done_o,
    output logic                   error_o
);

    localparam int unsigned BATCH_W = (BATCH_LEN > 1) ? $clog2(BATCH_LEN) : 1;
    localparam int unsigned TMO_W   = $clog2(CORE_TIMEOUT + 1);
    localparam logic [BATCH_W-1:0] BATCH_LAST = BATCH_W'(BATCH_LEN - 1);
    // Counter value in the last WAIT cycle before the timeout is declared.
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(CORE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DATA_LENGTH-1:0] x_next;
    logic [DATA_LENGTH-1:0] data_next;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [TMO_W-1:0]       tmo_next;
    logic [BATCH_W-1:0]     batch_cnt;
    logic [BATCH_W-1:0]     batch_next;
    logic                   error_next;
    logic                   done_next;

    // The modulus is a constant tie-off, valid even during reset.
    assign core_m_o = DATA_LENGTH'(MODULUS);

    // Next-state and next-register-value logic.
    always_comb begin
        state_next = state;
        x_next     = core_x_o;
        data_next  = out_data_o;
        tmo_next   = tmo_cnt;
        batch_next = batch_cnt;
        error_next = error_o;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    if (in_data_i != '0) begin
                        x_next     = in_data_i;
                        state_next = ISSUE;
                    end else begin
                        // 0 mod q is 0: skip the core entirely.
                        data_next  = '0;
                        state_next = OUT;
                    end
                end
            end
            ISSUE: begin
                tmo_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (core_valid_i) begin
                    data_next  = core_result_i;
                    state_next = OUT;
                end else if (tmo_cnt == TMO_LAST) begin
                    // Core hung: drop this coefficient and keep going.
                    error_next = 1'b1;
                    tmo_next   = '0;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_cnt + TMO_W'(1);
                end
            end
            OUT: begin
                if (out_ready_i) begin
                    if (batch_cnt == BATCH_LAST) begin
                        batch_next = '0;
                        done_next  = 1'b1;
                    end else begin
                        batch_next = batch_cnt + BATCH_W'(1);
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; handshake outputs decode the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            core_x_o     <= '0;
            out_data_o   <= '0;
            tmo_cnt      <= '0;
            batch_cnt    <= '0;
            error_o      <= 1'b0;
            batch_done_o <= 1'b0;
            in_ready_o   <= 1'b0;
            core_start_o <= 1'b0;
            out_valid_o  <= 1'b0;
        end else begin
            state        <= state_next;
            core_x_o     <= x_next;
            out_data_o   <= data_next;
            tmo_cnt      <= tmo_next;
            batch_cnt    <= batch_next;
            error_o      <= error_next;
            batch_done_o <= done_next;
            in_ready_o   <= (state_next == IDLE);
            core_start_o <= (state_next == ISSUE);
            out_valid_o  <= (state_next == OUT);
        end
    end

endmodule

// File: tb/tb_kyber_reduce_sequencer.sv
// Scoreboard bench for kyber_reduce_sequencer: the driver pushes expected
// results (x mod 3329) into a queue, a monitor pops them on each output
// handshake, and a behavioural core model answers start pulses.
module tb_kyber_reduce_sequencer;

    localparam int unsigned Q = 3329;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_data_i = '0;
    logic        core_start_o;
    logic [31:0] core_x_o;
    logic [31:0] core_m_o;
    logic        core_valid_i = 1'b0;
    logic [31:0] core_result_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_data_o;
    logic        batch_done_o;
    logic        error_o;

    kyber_reduce_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .core_start_o (core_start_o),
        .core_x_o     (core_x_o),
        .core_m_o     (core_m_o),
        .core_valid_i (core_valid_i),
        .core_result_i(core_result_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .batch_done_o (batch_done_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          n_starts = 0;
    int          n_done = 0;
    int          rst_epoch = 0;
    logic [31:0] exp_q[$];
    logic [31:0] xq[$];

    // Core-model and downstream controls written only by the main process.
    bit          core_hang = 1'b0;
    int          fix_lat = 0;
    bit          force_res_en = 1'b0;
    logic [31:0] force_res = '0;
    bit          stray_pulse = 1'b0;
    bit          bp_en = 1'b0;
    bit          ready_force = 1'b1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: random backpressure or a forced level.
    initial begin
        forever begin
            step();
            out_ready_i = bp_en ? ($urandom_range(0, 1) == 1) : ready_force;
        end
    end

    // Behavioural reduction core: answers each start after a latency.
    initial begin
        logic [31:0] xe;
        int          lat;
        int          ep;
        bit          have;
        forever begin
            step();
            core_valid_i  = stray_pulse;
            core_result_i = stray_pulse ? 32'hDEAD_BEEF : 32'h0;
            if (core_start_o && !rst) begin
                n_starts++;
                have = (xq.size() != 0);
                if (!have) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_core_start: got x=%h expected no start", core_x_o);
                end else begin
                    xe = xq.pop_front();
                    chk("core_x", core_x_o, xe);
                end
                chk("core_m", core_m_o, 32'(Q));
                if (have && !core_hang) begin
                    ep  = rst_epoch;
                    lat = (fix_lat != 0) ? fix_lat : $urandom_range(1, 20);
                    repeat (lat) begin
                        step();
                        core_valid_i = 1'b0;
                    end
                    if (ep == rst_epoch) chk("core_x_hold", core_x_o, xe);
                    core_valid_i  = 1'b1;
                    core_result_i = force_res_en ? force_res : (xe % 32'(Q));
                end
            end
        end
    end

    // Monitor: scoreboard pop, hold-under-backpressure and batch pulse checks.
    initial begin
        int          hs = 0;
        bit          exp_done = 1'b0;
        bit          pend = 1'b0;
        logic [31:0] pend_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hs = 0;
                exp_done = 1'b0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("hold_valid", 32'(out_valid_o), 32'd1);
                    chk("hold_data", out_data_o, pend_data);
                end
                if (exp_done || batch_done_o) chk("batch_done", 32'(batch_done_o), 32'(exp_done));
                if (batch_done_o) n_done++;
                exp_done = 1'b0;
                if (out_valid_o && out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: got %h expected none", out_data_o);
                    end else begin
                        chk("out_data", out_data_o, exp_q.pop_front());
                    end
                    hs++;
                    if (hs % 256 == 0) exp_done = 1'b1;
                end
                pend      = out_valid_o && !out_ready_i;
                pend_data = out_data_o;
            end
        end
    end

    // Present one coefficient; returns the accept cycle.
    task automatic send(input logic [31:0] x, input logic [31:0] e,
                        input bit expect_out, output int t_acc);
        int n = 0;
        in_valid_i = 1'b1;
        in_data_i  = x;
        while (!in_ready_o && n < 500) begin
            step();
            n++;
        end
        t_acc = cyc;
        if (!in_ready_o) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 for x=%h", x);
        end else begin
            if (x != 0) xq.push_back(x);
            if (expect_out) exp_q.push_back(e);
        end
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rst_epoch++;
        exp_q.delete();
        xq.delete();
        repeat (2) step();
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        chk("rst_core_start", 32'(core_start_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_batch_done", 32'(batch_done_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_core_x", core_x_o, 32'd0);
        chk("rst_out_data", out_data_o, 32'd0);
        chk("rst_core_m", core_m_o, 32'(Q));
        chk("rst_batch_cnt", 32'(dut.batch_cnt), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t;
        int          n;
        logic [31:0] x;

        // Single coefficient with a fixed core answer and 3-cycle latency.
        #1;
        do_reset();
        n_starts     = 0;
        fix_lat      = 3;
        force_res_en = 1'b1;
        force_res    = 32'h0676;
        send(32'h1234, 32'h0676, 1'b1, t);
        drain();
        force_res_en = 1'b0;
        chk("single_start_count", 32'(n_starts), 32'd1);

        // Zero bypass: no core start, output one cycle after accept.
        n_starts = 0;
        send(32'h0, 32'h0, 1'b1, t);
        chk("zero_out_valid", 32'(out_valid_o), 32'd1);
        chk("zero_out_data", out_data_o, 32'd0);
        drain();
        chk("zero_no_start", 32'(n_starts), 32'd0);

        // Backpressure for 10 cycles with stray core valids.
        ready_force = 1'b0;
        step();
        send(32'd7000, 32'd7000 % 32'(Q), 1'b1, t);
        n = 0;
        while (!out_valid_o && n < 100) begin
            step();
            n++;
        end
        chk("bp_out_valid_seen", 32'(out_valid_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            stray_pulse = (i % 2 == 0);
            chk("bp_out_valid", 32'(out_valid_o), 32'd1);
            chk("bp_out_data", out_data_o, 32'd342);
            chk("bp_in_ready", 32'(in_ready_o), 32'd0);
            step();
        end
        stray_pulse = 1'b0;
        step();
        ready_force = 1'b1;
        drain();

        // One full batch of random coefficients, latency and backpressure.
        do_reset();
        fix_lat = 0;
        n_done  = 0;
        bp_en   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            x = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            send(x, x % 32'(Q), 1'b1, t);
            if ($urandom_range(0, 3) == 0) step();
        end
        drain();
        bp_en = 1'b0;
        step();
        chk("batch_done_count", 32'(n_done), 32'd1);
        chk("batch_cnt_wrap", 32'(dut.batch_cnt), 32'd0);

        // Core hang: error at accept+66, no output, then recovery.
        core_hang = 1'b1;
        send(32'd5000, 32'd0, 1'b0, t);
        n = 0;
        while (!error_o && n < 200) begin
            step();
            n++;
        end
        chk("err_time", 32'(cyc - t), 32'd66);
        chk("err_in_ready", 32'(in_ready_o), 32'd1);
        core_hang = 1'b0;
        send(32'd3330, 32'd1, 1'b1, t);
        drain();
        chk("err_sticky", 32'(error_o), 32'd1);

        // Reset while waiting on the core; the late core valid is ignored.
        fix_lat = 15;
        send(32'd1000, 32'd1000, 1'b1, t);
        repeat (3) step();
        do_reset();
        repeat (30) step();
        chk("abort_out_valid", 32'(out_valid_o), 32'd0);
        chk("abort_in_ready", 32'(in_ready_o), 32'd1);
        fix_lat = 2;
        send(32'd3329, 32'd0, 1'b1, t);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
